// File: rtl/usr_if.sv
// Control, data and status bundle of the universal shift register.
// The master side drives the operation; the slave side is the register itself.
interface usr_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             en;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pd;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    shift_cnt;
  logic             done;

  modport master (
    output en, mode, sin_r, sin_l, pd,
    input  q, sout_r, sout_l, shift_cnt, done
  );

  modport slave (
    input  en, mode, sin_r, sin_l, pd,
    output q, sout_r, sout_l, shift_cnt, done
  );
endinterface

// File: rtl/universal_shift_register.sv
// WIDTH-bit hold / shift-right / shift-left / load register with a selectable
// active clock edge and a shift counter that pulses done every WIDTH shifts.
module universal_shift_register #(
  parameter int               WIDTH    = 8,
  parameter bit               NEG_EDGE = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input logic   clk,
  input logic   rst,
  usr_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // The edge choice is a constant, so this reduces to a wire or a single inverter.
  logic clk_act;
  assign clk_act = NEG_EDGE ? ~clk : clk;

  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;
  logic             done;

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             done_nxt;
  logic             is_shift;

  always_comb begin
    q_nxt    = q;
    cnt_nxt  = cnt;
    done_nxt = 1'b0;
    is_shift = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_RIGHT: begin
          q_nxt    = {bus.sin_r, q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_LEFT: begin
          q_nxt    = {q[WIDTH-2:0], bus.sin_l};
          is_shift = 1'b1;
        end
        MODE_LOAD: begin
          q_nxt   = bus.pd;
          cnt_nxt = '0;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
    // Direction changes do not clear the count; every shift advances it.
    if (is_shift) begin
      if (cnt == CNT_LAST) begin
        cnt_nxt  = '0;
        done_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_act or posedge rst) begin
    if (rst) begin
      q    <= RST_VAL;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      q    <= q_nxt;
      cnt  <= cnt_nxt;
      done <= done_nxt;
    end
  end

  assign bus.q         = q;
  assign bus.shift_cnt = cnt;
  assign bus.done      = done;
  assign bus.sout_r    = q[0];
  assign bus.sout_l    = q[WIDTH-1];
endmodule
